// File: rtl/int_priority_sequencer.sv
// Purpose : fixed-priority interrupt entry/return sequencer with a return-address stack.
// Latency : redirect/ifr_clr pulse one cycle after the accepting edge (all outputs registered).
// Backpressure: int_req holds until the CPU signals cpu_ready; reti is the only exit from service.
//
// Ports:
//   clk, rst          - single rising-edge clock, synchronous active-high reset
//   irq_pending       - per-source pending (already masked), lowest index wins
//   global_en         - global interrupt enable
//   cpu_ready, pc_in  - CPU at an instruction boundary, and the return address it offers
//   reti              - one-cycle return-from-interrupt pulse
//   int_req           - entry requested (state REQ)
//   redirect(_addr)   - one-cycle PC load of a handler or return address
//   ifr_clr(_id)      - one-cycle acknowledge of the accepted source
//   active_id, depth  - source in service (0 when idle) and nesting level
// Optional macro INT_NESTING_EN: enables preemption by a higher-priority source, up to
// STACK_DEPTH levels. Without it the stack holds a single entry and service is not preempted.

module int_priority_sequencer #(
    parameter int          NUM_INT        = 16,
    parameter logic [15:0] HANDLER_BASE   = 16'h0100,
    parameter logic [15:0] HANDLER_STRIDE = 16'h0010,
    parameter int          STACK_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_INT-1:0]           irq_pending,
    input  logic                         global_en,
    input  logic                         cpu_ready,
    input  logic [15:0]                  pc_in,
    input  logic                         reti,
    output logic                         int_req,
    output logic                         redirect,
    output logic [15:0]                  redirect_addr,
    output logic                         ifr_clr,
    output logic [$clog2(NUM_INT)-1:0]   ifr_clr_id,
    output logic [$clog2(NUM_INT)-1:0]   active_id,
    output logic [$clog2(STACK_DEPTH):0] depth
);

    localparam int IDW = $clog2(NUM_INT);
    localparam int DW  = $clog2(STACK_DEPTH) + 1;
`ifdef INT_NESTING_EN
    localparam int LEVELS = STACK_DEPTH;
`else
    localparam int LEVELS = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  lat_q, lat_d;
    logic [DW-1:0]   depth_q;

    // Shift stack: entry 0 is always the top, so no depth-based indexing is needed.
    logic [15:0]     stk_pc [LEVELS];
    logic [IDW-1:0]  stk_id [LEVELS];

    logic [IDW-1:0]  win_id;
    logic            any_pend;
    logic            preempt;
    logic            push, pop;
    logic            redirect_d, ifr_clr_d;
    logic [15:0]     redirect_addr_d;
    logic [IDW-1:0]  ifr_clr_id_d;
    logic [15:0]     hnd_addr;

    // Lowest set index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        win_id = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (irq_pending[i]) win_id = IDW'(i);
        end
    end

    assign any_pend  = |irq_pending;
    assign hnd_addr  = HANDLER_BASE + 16'(lat_q) * HANDLER_STRIDE;
    assign active_id = (depth_q != '0) ? stk_id[0] : '0;
    assign depth     = depth_q;
    assign int_req   = (state_q == S_REQ);

`ifdef INT_NESTING_EN
    // Only a strictly higher-priority source may preempt, and only with a free stack slot.
    assign preempt = global_en && any_pend && (win_id < active_id) && (depth_q < DW'(LEVELS));
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        lat_d           = lat_q;
        push            = 1'b0;
        pop             = 1'b0;
        redirect_d      = 1'b0;
        redirect_addr_d = redirect_addr;
        ifr_clr_d       = 1'b0;
        ifr_clr_id_d    = ifr_clr_id;
        case (state_q)
            S_IDLE: begin
                if (global_en && any_pend) begin
                    lat_d   = win_id;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Losing global_en cancels the request; fall back to whatever was running.
                if (!global_en) begin
                    state_d = (depth_q == '0) ? S_IDLE : S_SERVICE;
                end else if (cpu_ready) begin
                    push            = 1'b1;
                    redirect_d      = 1'b1;
                    redirect_addr_d = hnd_addr;
                    ifr_clr_d       = 1'b1;
                    ifr_clr_id_d    = lat_q;
                    state_d         = S_SERVICE;
                end
            end
            S_SERVICE: begin
                // reti takes precedence; new sources are looked at again next cycle.
                if (reti) begin
                    pop             = 1'b1;
                    redirect_d      = 1'b1;
                    redirect_addr_d = stk_pc[0];
                    state_d         = (depth_q == DW'(1)) ? S_IDLE : S_SERVICE;
                end else if (preempt) begin
                    lat_d   = win_id;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lat_q         <= '0;
            depth_q       <= '0;
            redirect      <= 1'b0;
            redirect_addr <= '0;
            ifr_clr       <= 1'b0;
            ifr_clr_id    <= '0;
            for (int i = 0; i < LEVELS; i++) begin
                stk_pc[i] <= '0;
                stk_id[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            redirect      <= redirect_d;
            redirect_addr <= redirect_addr_d;
            ifr_clr       <= ifr_clr_d;
            ifr_clr_id    <= ifr_clr_id_d;
            if (push) begin
                for (int i = LEVELS - 1; i > 0; i--) begin
                    stk_pc[i] <= stk_pc[i-1];
                    stk_id[i] <= stk_id[i-1];
                end
                stk_pc[0] <= pc_in;
                stk_id[0] <= lat_q;
                depth_q   <= depth_q + DW'(1);
            end else if (pop) begin
                for (int i = 0; i < LEVELS - 1; i++) begin
                    stk_pc[i] <= stk_pc[i+1];
                    stk_id[i] <= stk_id[i+1];
                end
                stk_pc[LEVELS-1] <= '0;
                stk_id[LEVELS-1] <= '0;
                depth_q          <= depth_q - DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_int_priority_sequencer.sv
// Purpose : self-checking bench for int_priority_sequencer (directed scenarios + random traffic).
// Latency : every cycle the outputs are compared against a queue-based reference model.
// Backpressure: cpu_ready and global_en are toggled to exercise held and aborted requests.

module tb_int_priority_sequencer;

    localparam int NUM_INT  = 16;
    localparam int SD       = 4;
    localparam int H_BASE   = 'h0100;
    localparam int H_STRIDE = 'h0010;
`ifdef INT_NESTING_EN
    localparam int M_LEVELS = SD;
    localparam bit NEST     = 1'b1;
`else
    localparam int M_LEVELS = 1;
    localparam bit NEST     = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] irq_pending;
    logic        global_en;
    logic        cpu_ready;
    logic [15:0] pc_in;
    logic        reti;
    logic        int_req;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        ifr_clr;
    logic [3:0]  ifr_clr_id;
    logic [3:0]  active_id;
    logic [2:0]  depth;

    int n_chk  = 0;
    int n_fail = 0;

    int_priority_sequencer #(
        .NUM_INT        (NUM_INT),
        .HANDLER_BASE   (16'h0100),
        .HANDLER_STRIDE (16'h0010),
        .STACK_DEPTH    (SD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_pending   (irq_pending),
        .global_en     (global_en),
        .cpu_ready     (cpu_ready),
        .pc_in         (pc_in),
        .reti          (reti),
        .int_req       (int_req),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .ifr_clr       (ifr_clr),
        .ifr_clr_id    (ifr_clr_id),
        .active_id     (active_id),
        .depth         (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = waiting, 1 = requesting, 2 = in a handler.
    // The nesting stack is a pair of queues whose front is the innermost handler.
    int m_mode = 0;
    int m_lat  = 0;
    int m_pc[$];
    int m_id[$];
    bit e_redir = 1'b0;
    bit e_clr   = 1'b0;
    int e_addr  = 0;
    int e_clrid = 0;
    bit m_vals  = 1'b0;

    function automatic int lowest(input logic [15:0] p);
        int r = -1;
        for (int i = NUM_INT - 1; i >= 0; i--) if (p[i]) r = i;
        return r;
    endfunction

    function automatic int m_act();
        return (m_id.size() != 0) ? m_id[0] : 0;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_mode = 0;
            m_pc.delete();
            m_id.delete();
            e_redir = 1'b0;
            e_clr   = 1'b0;
            e_addr  = 0;
            e_clrid = 0;
            m_vals  = 1'b1;
        end else begin
            m_vals  = 1'b0;
            e_redir = 1'b0;
            e_clr   = 1'b0;
            case (m_mode)
                0: if (global_en && irq_pending != 0) begin
                    m_lat  = lowest(irq_pending);
                    m_mode = 1;
                end
                1: if (!global_en) begin
                    m_mode = (m_pc.size() == 0) ? 0 : 2;
                end else if (cpu_ready) begin
                    m_pc.push_front(int'(pc_in));
                    m_id.push_front(m_lat);
                    e_redir = 1'b1;
                    e_addr  = (H_BASE + m_lat * H_STRIDE) & 'hFFFF;
                    e_clr   = 1'b1;
                    e_clrid = m_lat;
                    m_mode  = 2;
                end
                default: if (reti) begin
                    e_redir = 1'b1;
                    e_addr  = m_pc.pop_front();
                    void'(m_id.pop_front());
                    m_mode  = (m_pc.size() == 0) ? 0 : 2;
                end else if (NEST && global_en && irq_pending != 0 &&
                             lowest(irq_pending) < m_act() && m_pc.size() < M_LEVELS) begin
                    m_lat  = lowest(irq_pending);
                    m_mode = 1;
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        chk_eq("int_req",   32'(int_req),   32'(m_mode == 1));
        chk_eq("redirect",  32'(redirect),  32'(e_redir));
        chk_eq("ifr_clr",   32'(ifr_clr),   32'(e_clr));
        chk_eq("depth",     32'(depth),     32'(m_pc.size()));
        chk_eq("active_id", 32'(active_id), 32'(m_act()));
        if (e_redir || m_vals) chk_eq("redirect_addr", 32'(redirect_addr), 32'(e_addr));
        if (e_clr || m_vals)   chk_eq("ifr_clr_id",    32'(ifr_clr_id),    32'(e_clrid));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge,
    // then the IFR bit is cleared on acknowledge and reti is dropped (one-cycle pulse).
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        if (ifr_clr) irq_pending[ifr_clr_id] = 1'b0;
        reti = 1'b0;
    endtask

    initial begin
        logic [3:0] b;
        rst = 1'b1; irq_pending = '0; global_en = 1'b0; cpu_ready = 1'b0;
        pc_in = '0; reti = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_eq("rst_depth",    32'(depth),         32'd0);
        chk_eq("rst_int_req",  32'(int_req),       32'd0);
        chk_eq("rst_redir_ad", 32'(redirect_addr), 32'd0);

        // Single source 5, then return.
        irq_pending = 16'h0020; global_en = 1'b1; cpu_ready = 1'b1; pc_in = 16'h0042;
        step();
        chk_eq("s5_int_req", 32'(int_req), 32'd1);
        step();
        chk_eq("s5_addr",  32'(redirect_addr), 32'h0150);
        chk_eq("s5_clrid", 32'(ifr_clr_id),    32'd5);
        chk_eq("s5_depth", 32'(depth),         32'd1);
        step();
        step();
        reti = 1'b1;
        step();
        chk_eq("s5_ret_redir", 32'(redirect),      32'd1);
        chk_eq("s5_ret_addr",  32'(redirect_addr), 32'h0042);
        chk_eq("s5_ret_depth", 32'(depth),         32'd0);
        step();
        chk_eq("s5_idle_req", 32'(int_req), 32'd0);

        // Two sources: 0 first, then 1 after the return.
        irq_pending = 16'h0003; pc_in = 16'h0055;
        step();
        step();
        chk_eq("p0_addr", 32'(redirect_addr), 32'h0100);
        step();
        reti = 1'b1;
        step();
        chk_eq("p0_ret_addr", 32'(redirect_addr), 32'h0055);
        step();
        step();
        chk_eq("p1_addr",  32'(redirect_addr), 32'h0110);
        chk_eq("p1_clrid", 32'(ifr_clr_id),    32'd1);
        reti = 1'b1;
        step();
        step();

`ifdef INT_NESTING_EN
        // Preemption of handler 4 by source 2.
        irq_pending = 16'h0010; pc_in = 16'h0042;
        step();
        step();
        chk_eq("n4_addr", 32'(redirect_addr), 32'h0140);
        irq_pending = 16'h0004; pc_in = 16'h0300;
        step();
        chk_eq("n2_int_req", 32'(int_req), 32'd1);
        step();
        chk_eq("n2_addr",  32'(redirect_addr), 32'h0120);
        chk_eq("n2_depth", 32'(depth),         32'd2);
        reti = 1'b1;
        step();
        chk_eq("n2_ret_addr", 32'(redirect_addr), 32'h0300);
        reti = 1'b1;
        step();
        chk_eq("n4_ret_addr", 32'(redirect_addr), 32'h0042);
        chk_eq("n4_ret_depth", 32'(depth), 32'd0);

        // Fill the stack, then a top-priority source must wait for a reti.
        for (int k = 0; k < 4; k++) begin
            irq_pending = 16'h0100 >> (2 * k);
            pc_in = 16'(16'h0A00 + k);
            step();
            step();
        end
        chk_eq("full_depth", 32'(depth), 32'd4);
        irq_pending = 16'h0001;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_eq("full_no_req", 32'(int_req), 32'd0);
        end
        reti = 1'b1;
        step();
        chk_eq("full_pop_depth", 32'(depth), 32'd3);
        step();
        chk_eq("full_req_after", 32'(int_req), 32'd1);
        step();
        chk_eq("full_b0_addr", 32'(redirect_addr), 32'h0100);
        for (int k = 0; k < 4; k++) begin
            reti = 1'b1;
            step();
        end
`else
        // Without nesting a higher-priority source waits for the return.
        irq_pending = 16'h0010; pc_in = 16'h0042;
        step();
        step();
        irq_pending = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_eq("nonest_no_req", 32'(int_req), 32'd0);
            chk_eq("nonest_depth",  32'(depth),   32'd1);
        end
        reti = 1'b1;
        step();
        chk_eq("nonest_ret_addr", 32'(redirect_addr), 32'h0042);
        step();
        chk_eq("nonest_req", 32'(int_req), 32'd1);
        step();
        chk_eq("nonest_b0_addr", 32'(redirect_addr), 32'h0100);
        reti = 1'b1;
        step();
`endif

        // Reset in the middle of (possibly nested) service discards the stack.
        irq_pending = 16'h0010; pc_in = 16'h0123;
        step();
        step();
`ifdef INT_NESTING_EN
        irq_pending = 16'h0004;
        step();
        step();
        chk_eq("mid_depth2", 32'(depth), 32'd2);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_eq("mid_rst_depth",  32'(depth),     32'd0);
        chk_eq("mid_rst_redir",  32'(redirect),  32'd0);
        chk_eq("mid_rst_clr",    32'(ifr_clr),   32'd0);
        chk_eq("mid_rst_active", 32'(active_id), 32'd0);
        chk_eq("mid_rst_req",    32'(int_req),   32'd0);
        irq_pending = '0; reti = 1'b1;
        step();
        chk_eq("mid_reti_redir", 32'(redirect), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            global_en = ($urandom_range(0, 9) != 0);
            cpu_ready = 1'($urandom_range(0, 1));
            pc_in     = 16'($urandom);
            reti      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) begin
                b = 4'($urandom_range(0, 15));
                irq_pending[b] = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int_priority_sequencer.md
INT_PRIORITY_SEQUENCER -- requirements
Module: int_priority_sequencer

Interface
REQ-001 Parameter NUM_INT, default 16, number of interrupt sources.
REQ-002 Parameter HANDLER_BASE, default 16'h0100, handler address of source 0.
REQ-003 Parameter HANDLER_STRIDE, default 16'h0010, address step between consecutive handlers.
REQ-004 Parameter STACK_DEPTH, default 4, maximum nesting levels (effective only with INT_NESTING_EN).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 irq_pending  in  NUM_INT  per-source pending, already masked (IER & IFR).
REQ-008 global_en  in  1  global interrupt enable (IER top bit).
REQ-009 cpu_ready  in  1  CPU is at an instruction boundary and accepts a redirect this cycle.
REQ-010 pc_in  in  16  return address offered by the CPU while cpu_ready=1.
REQ-011 reti  in  1  one-cycle pulse: handler executed return-from-interrupt.
REQ-012 int_req  out  1  interrupt entry requested.
REQ-013 redirect  out  1  one-cycle pulse: load redirect_addr into PC.
REQ-014 redirect_addr  out  16  handler or return address, valid only with redirect.
REQ-015 ifr_clr  out  1  one-cycle pulse: clear the IFR bit at ifr_clr_id.
REQ-016 ifr_clr_id  out  $clog2(NUM_INT)  source being acknowledged.
REQ-017 active_id  out  $clog2(NUM_INT)  source currently in service; 0 when depth=0.
REQ-018 depth  out  $clog2(STACK_DEPTH)+1  current nesting level.

Function
REQ-019 Priority: lowest set index wins, fixed; the winner is latched when leaving IDLE or SERVICE and is not re-evaluated in REQ.
REQ-020 FSM states: IDLE, REQ, SERVICE.
REQ-021 IDLE: if global_en=1 and |irq_pending, latch the winner and go to REQ on the next edge; otherwise stay.
REQ-022 REQ: int_req=1; on a cycle with cpu_ready=1, push pc_in and the latched id, increment depth, pulse redirect with HANDLER_BASE + id*HANDLER_STRIDE (16-bit wrap), pulse ifr_clr with that id, and enter SERVICE; all outputs are registered (1-cycle latency).
REQ-023 REQ with global_en dropping to 0 before acceptance: abort and return to IDLE if depth=0, or to SERVICE otherwise; no push and no pulses.
REQ-024 SERVICE: on reti, pop the stack, pulse redirect with the popped address, and decrement depth; go to IDLE if the new depth is 0, else remain in SERVICE with active_id set to the new top entry.
REQ-025 reti and a new pending source in the same cycle: reti is processed; pending sources are re-evaluated on the following cycle.
REQ-026 reti while depth=0: ignored, with no output change.
REQ-027 redirect and ifr_clr are never asserted for more than one consecutive cycle per event.

Reset
REQ-028 While rst=1 at the clock edge: state=IDLE, depth=0, stack cleared, int_req=0, redirect=0, redirect_addr=0, ifr_clr=0, ifr_clr_id=0, active_id=0.
REQ-029 rst asserted mid-operation (REQ or SERVICE) discards all nesting; no return redirect is issued.

Configuration
REQ-030 Macro INT_NESTING_EN defined: in SERVICE, a pending source with index < active_id and global_en=1 moves the FSM to REQ (preemption), provided depth < STACK_DEPTH; when the stack is full, preemption is suppressed until a reti.
REQ-031 INT_NESTING_EN undefined: the stack is a single entry, depth never exceeds 1, and SERVICE ignores irq_pending until reti.

Verification
REQ-032 irq_pending=16'h0020, global_en=1, cpu_ready=1, pc_in=16'h0042 -> redirect to 16'h0150, ifr_clr_id=5, depth=1; later reti -> redirect to 16'h0042, depth=0, IDLE.
REQ-033 irq_pending=16'h0003 -> id 0 serviced first, redirect 16'h0100; after reti with bit 1 still pending -> id 1 serviced, redirect 16'h0110.
REQ-034 INT_NESTING_EN, in service of id 4 at pc 16'h0300: raise bit 2 -> preempt, redirect 16'h0120, depth=2; two retis -> redirects 16'h0300 then the original pc.
REQ-035 INT_NESTING_EN, STACK_DEPTH=4, depth=4: assert bit 0 -> no int_req until a reti; without the macro, bit 0 during service -> no preemption.
REQ-036 rst pulsed while depth=2 -> all outputs 0 next cycle, and a subsequent reti produces no redirect.
